// File: rtl/freq_gate_counter_if.sv
// Signal bundle between the frequency gate counter and its host.
// The ovf line exists only when FREQ_OVF_EN is defined.
interface freq_gate_counter_if;
  logic        sig_in;
  logic        meas_en;
  logic [27:0] freq;
  logic        freq_vld;
  logic        busy;
`ifdef FREQ_OVF_EN
  logic        ovf;
`endif

  modport master (
    output sig_in, meas_en,
`ifdef FREQ_OVF_EN
    input  ovf,
`endif
    input  freq, freq_vld, busy
  );

  modport slave (
    input  sig_in, meas_en,
`ifdef FREQ_OVF_EN
    output ovf,
`endif
    output freq, freq_vld, busy
  );
endinterface

// File: rtl/freq_gate_counter.sv
// Gated edge counter: counts sig_in rising edges over CLK_FREQ sys_clk cycles.
// Define FREQ_OVF_EN to saturate the count at MAX_FREQ and drive the ovf flag.
//
// state | meaning
// IDLE  | counters held at 0, waiting for meas_en
// GATE  | gate running, gate_cnt steps every cycle, rises accumulate
module freq_gate_counter #(
  parameter int CLK_FREQ    = 48_000_000,
  parameter int SYNC_STAGES = 2
`ifdef FREQ_OVF_EN
  ,
  parameter int MAX_FREQ    = 99_999_999
`endif
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  freq_gate_counter_if.slave   bus
);

  localparam logic [27:0] GATE_LAST = 28'(CLK_FREQ - 1);
`ifdef FREQ_OVF_EN
  localparam logic [27:0] SAT_VAL = 28'(MAX_FREQ);
`endif

  typedef enum logic {IDLE, GATE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed;
  logic                   rise;
  logic [27:0]            gate_cnt, gate_cnt_nxt;
  logic [27:0]            edge_cnt, edge_cnt_nxt;
  logic [27:0]            edge_step;
  logic [27:0]            total;
  logic [27:0]            freq_q, freq_nxt;
  logic                   vld_q, vld_nxt;
`ifdef FREQ_OVF_EN
  logic                   ovf_q, ovf_nxt;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= '0;
      delayed <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      delayed <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = sync_q[SYNC_STAGES-1] & ~delayed;
  // Rise in the gate's last cycle still belongs to that gate.
  assign total = edge_cnt + {27'd0, rise};

`ifdef FREQ_OVF_EN
  assign edge_step = (edge_cnt >= SAT_VAL) ? SAT_VAL : total;
`else
  assign edge_step = total;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      freq_q   <= '0;
      vld_q    <= 1'b0;
`ifdef FREQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
      freq_q   <= freq_nxt;
      vld_q    <= vld_nxt;
`ifdef FREQ_OVF_EN
      ovf_q    <= ovf_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = '0;
    edge_cnt_nxt = '0;
    freq_nxt     = freq_q;
    vld_nxt      = 1'b0;
`ifdef FREQ_OVF_EN
    ovf_nxt      = ovf_q;
`endif
    case (state)
      IDLE: begin
        if (bus.meas_en) state_nxt = GATE;
      end
      GATE: begin
        // Abort takes priority over a gate that would end this cycle.
        if (!bus.meas_en) begin
          state_nxt = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          vld_nxt = 1'b1;
`ifdef FREQ_OVF_EN
          freq_nxt = (total >= SAT_VAL) ? SAT_VAL : total;
          ovf_nxt  = (total >= SAT_VAL);
`else
          freq_nxt = total;
`endif
        end else begin
          gate_cnt_nxt = gate_cnt + 28'd1;
          edge_cnt_nxt = edge_step;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.freq     = freq_q;
  assign bus.freq_vld = vld_q;
  assign bus.busy     = (state == GATE);
`ifdef FREQ_OVF_EN
  assign bus.ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: directed scenes plus random stimulus, checked
// every cycle against a windowed edge-count reference model.
module tb_freq_gate_counter;
  localparam int CF   = 100;
  localparam int S    = 2;
  localparam int MAXC = 8000;
`ifdef FREQ_OVF_EN
  localparam int MAXF = 20;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_gate_counter_if bus();

  freq_gate_counter #(
    .CLK_FREQ(CF),
    .SYNC_STAGES(S)
`ifdef FREQ_OVF_EN
    ,
    .MAX_FREQ(MAXF)
`endif
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: sig_in as seen at each clock edge, gate windows by edge index.
  int n = 0;
  bit s_hist [MAXC];
  bit m_gate = 1'b0;
  int gf = 0;
  int e_freq = 0;
  bit e_vld = 1'b0;
  bit e_ovf = 1'b0;

  function automatic int sat(int c);
`ifdef FREQ_OVF_EN
    return (c > MAXF) ? MAXF : c;
`else
    return c;
`endif
  endfunction

  // An input edge sampled at clock edge k is counted at clock edge k+S.
  function automatic int rise_at(int c);
    if (c - S - 1 < 0) return 0;
    return (s_hist[c-S] && !s_hist[c-S-1]) ? 1 : 0;
  endfunction

  always @(posedge clk) begin : ref_model
    int cnt;
    n = n + 1;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", n, MAXC);
      $fatal(1);
    end
    s_hist[n] = rst_n ? bus.sig_in : 1'b0;
    e_vld = 1'b0;
    if (!rst_n) begin
      m_gate = 1'b0;
      e_freq = 0;
      e_ovf  = 1'b0;
    end else if (!m_gate) begin
      if (bus.meas_en) begin
        m_gate = 1'b1;
        gf = n + 1;
      end
    end else if (!bus.meas_en) begin
      m_gate = 1'b0;
    end else if (n == gf + CF - 1) begin
      cnt = 0;
      for (int c = gf; c <= n; c++) cnt += rise_at(c);
      e_freq = sat(cnt);
`ifdef FREQ_OVF_EN
      e_ovf  = (cnt >= MAXF);
`endif
      e_vld  = 1'b1;
      gf = n + 1;
    end
  end

  always @(negedge clk) begin
    check_val("vld", bus.freq_vld, e_vld);
    check_val("busy", bus.busy, m_gate);
    check_val("freq", bus.freq, e_freq);
`ifdef FREQ_OVF_EN
    check_val("ovf", bus.ovf, e_ovf);
`endif
  end

  // sig_in driver: 0 = hold level, 1 = square wave with half period hp, 2 = random
  int mode = 1;
  int hp = 2;
  int ph = 0;
  int rcnt = 0;
  bit level = 1'b0;

  initial begin
    bus.sig_in = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (mode)
        0: bus.sig_in = level;
        1: begin
          ph++;
          if (ph >= hp) begin
            ph = 0;
            bus.sig_in = ~bus.sig_in;
          end
        end
        default: begin
          if (rcnt == 0) begin
            bus.sig_in = ~bus.sig_in;
            rcnt = $urandom_range(1, 11);
          end else rcnt--;
        end
      endcase
    end
  end

  task automatic wait_vld(output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.freq_vld === 1'b1) begin
        at = n;
        break;
      end
    end
    if (at < 0) check_val("vld_timeout", bus.freq_vld, 1);
  endtask

  task automatic wait_edge(int target);
    for (int k = 0; k < 300 && n != target; k++) @(negedge clk);
    check_val("reach_edge", n, target);
  endtask

  initial begin
    int e0, v, prev, k, off_cnt;
    bus.meas_en = 1'b1;
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b1;
    e0 = n + 1;

    // Back-to-back gates, period 4
    wait_vld(v);
    check_val("first_latency", v - e0, CF);
    check_val("first_freq_rng", (bus.freq >= sat(24) && bus.freq <= sat(26)), 1);
    for (int i = 0; i < 3; i++) begin
      prev = v;
      wait_vld(v);
      check_val("vld_period", v - prev, CF);
      check_val("freq_p4", bus.freq, sat(25));
    end

    // Constant high input
    mode = 0;
    level = 1'b1;
    wait_vld(v);
    wait_vld(v);
    check_val("const_freq", bus.freq, 0);

    // Single rise landing in the gate's last cycle
    level = 1'b0;
    wait_edge(gf + 96);
    level = 1'b1;
    wait_vld(v);
    check_val("last_cycle_edge", bus.freq, 1);
    wait_vld(v);
    check_val("edge_not_carried", bus.freq, 0);

    // Abort at gate_cnt 50, then restart
    mode = 1;
    hp = 2;
    wait_vld(v);
    wait_vld(v);
    wait_edge(gf + 49);
    bus.meas_en = 1'b0;
    @(negedge clk);
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_vld", bus.freq_vld, 0);
    check_val("abort_freq", bus.freq, sat(25));
    repeat (5) @(negedge clk);
    bus.meas_en = 1'b1;
    k = n;
    wait_vld(v);
    check_val("restart_latency", v - (k + 1), CF);
    check_val("restart_freq", bus.freq, sat(25));

    // Abort coinciding with the gate's last cycle
    wait_edge(gf + 98);
    bus.meas_en = 1'b0;
    @(negedge clk);
    check_val("abort_last_vld", bus.freq_vld, 0);
    check_val("abort_last_busy", bus.busy, 0);
    bus.meas_en = 1'b1;

    // Reset mid-gate
    wait_vld(v);
    wait_vld(v);
    check_val("pre_reset_freq", bus.freq, sat(25));
    wait_edge(gf + 69);
    #3 rst_n = 1'b0;
    #1;
    check_val("rst_freq", bus.freq, 0);
    check_val("rst_vld", bus.freq_vld, 0);
    check_val("rst_busy", bus.busy, 0);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b1;
    wait_vld(v);
    wait_vld(v);
    check_val("post_reset_freq", bus.freq, sat(25));

    // Random input and random enable drops
    mode = 2;
    off_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!bus.meas_en) begin
        if (off_cnt == 0) bus.meas_en = 1'b1;
        else off_cnt--;
      end else if ($urandom_range(0, 249) == 0) begin
        bus.meas_en = 1'b0;
        off_cnt = $urandom_range(0, 20);
      end
    end
    bus.meas_en = 1'b1;

`ifdef FREQ_OVF_EN
    mode = 1;
    hp = 2;
    wait_vld(v);
    wait_vld(v);
    check_val("sat_freq", bus.freq, 20);
    check_val("sat_ovf", bus.ovf, 1);
    hp = 5;
    wait_vld(v);
    wait_vld(v);
    check_val("p10_freq", bus.freq, 10);
    check_val("p10_ovf", bus.ovf, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
